pipe_ctrl: RTL and testbench
============================

// Module: pipe_ctrl
// PURPOSE
//  Hazard/exception sequencer for the 5-stage Y86-64 pipeline. Watches D/E/M/W pipeline-register fields.
//  Drives stall/bubble controls for f_reg, d_reg, e_reg, m_reg and w_reg, plus the CC write enable.
//  Owns the run-state FSM: IDLE -> RUN -> HALTED. Replaces ad-hoc $finish halting with a clean drain and a halted flag.
// PARAMETERS
//  CNT_W  32    width of the performance counters (PERF_CNT_EN only)
//  RNONE  4'hF  register ID meaning "no register"
// PORTS
//  clk        in   1      system clock; all state updates on posedge
//  rst        in   1      synchronous, active-high reset
//  go         in   1      start request, sampled in IDLE only
//  d_icode    in   4      icode in D register
//  d_srcA     in   4      decode srcA (RNONE if unused)
//  d_srcB     in   4      decode srcB (RNONE if unused)
//  e_icode    in   4      icode in E register
//  e_dstM     in   4      dstM of the instruction in E
//  e_cnd      in   1      execute condition result
//  m_icode    in   4      icode in M register
//  m_stat     in   3      stat in M; one-hot {HLT,INS,AOK}, AOK=3'b001
//  w_stat     in   3      stat in W; same encoding
//  f_stall    out  1      hold PC-predict register
//  d_stall    out  1      hold D register
//  d_bubble   out  1      load nop into D
//  e_bubble   out  1      load nop into E
//  m_bubble   out  1      load nop into M
//  w_stall    out  1      hold W register
//  set_cc     out  1      enable CC write in execute
//  cpu_stat   out  3      architectural status; registered
//  halted     out  1      1 once the FSM is in HALTED
// BEHAVIOUR
//  Opcodes: JXX=4'h7, MRMOVQ=4'h5, POPQ=4'hB, RET=4'h9, OPQ=4'h6.
//  Hazard terms (combinational, same cycle):
//   lu   = e_icode in {MRMOVQ,POPQ} && e_dstM != RNONE && e_dstM in {d_srcA,d_srcB}
//   ret  = RET in {d_icode,e_icode,m_icode}
//   misp = e_icode==JXX && !e_cnd
//   exc  = m_stat!=AOK || w_stat!=AOK
//  FSM states (2-bit register): IDLE=0, RUN=1, HALTED=2; 3 is illegal and recovers to IDLE next cycle.
//   IDLE: f_stall=1, d/e/m_bubble=1, d_stall=0, w_stall=0, set_cc=0. Pipeline fills with nops.
//         go=1 -> RUN on the next edge.
//   RUN outputs:
//    f_stall  = lu | ret
//    d_stall  = lu
//    d_bubble = misp | (ret & !lu)
//    e_bubble = misp | lu
//    m_bubble = exc
//    w_stall  = w_stat!=AOK
//    set_cc   = e_icode==OPQ & !exc
//   RUN transition: w_stat!=AOK -> HALTED next edge; cpu_stat <= w_stat on that same edge.
//   HALTED: f_stall=d_stall=w_stall=1; m_bubble=1; d/e_bubble=0; set_cc=0; halted=1.
//           Sticky; only rst leaves it. go is ignored.
//  Conflicts:
//   - lu and misp together: misp wins for D (d_bubble=1 overrides d_stall; d_stall forced 0).
//   - d_stall and d_bubble are never both 1.
//  Reset (rst=1 at posedge): state=IDLE, cpu_stat=3'b001, halted=0, counters=0.
//   Outputs take IDLE values in the cycle after the reset edge. Reset mid-RUN or mid-HALTED behaves the same.
//  go in RUN or HALTED has no effect. go and rst together: rst wins.
// CONFIGURATION
//  PERF_CNT_EN defined:
//   - Adds outputs cyc_cnt, stall_cnt, bub_cnt [CNT_W-1:0].
//   - Each counts in RUN only: cycles; cycles with lu; cycles with misp|ret.
//   - Each saturates at all-ones. All clear on rst.
//  PERF_CNT_EN undefined: the counter ports and logic are absent; all other behaviour is identical.
// TESTING
//  T1 rst=1 then go=0 for 5 cycles -> IDLE outputs held, cpu_stat=001, halted=0.
//  T2 RUN, e_icode=5, e_dstM=2, d_srcA=2 -> f_stall=1, d_stall=1, e_bubble=1, d_bubble=0 for exactly 1 cycle.
//  T3 RUN, e_icode=7, e_cnd=0, plus load-use on d_srcB -> d_bubble=1, e_bubble=1, d_stall=0.
//  T4 RUN, RET walks D->E->M (3 cycles) -> f_stall=1 and d_bubble=1 in each of the 3 cycles; then 0.
//  T5 RUN, m_stat=100 then w_stat=100 -> m_bubble=1, set_cc=0; next edge halted=1, cpu_stat=100.
//     rst -> IDLE, cpu_stat=001.
//  T6 (PERF_CNT_EN) 10 RUN cycles incl. 2 lu and 1 misp -> cyc_cnt=10, stall_cnt=2, bub_cnt=1.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Hazard/exception sequencer for the 5-stage Y86-64 pipeline with IDLE/RUN/HALTED run-state FSM.
// Optional performance counters are enabled by defining PERF_CNT_EN.
module pipe_ctrl #(
    parameter logic [3:0] RNONE = 4'hF
`ifdef PERF_CNT_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       go,
    input  logic [3:0] d_icode,
    input  logic [3:0] d_srcA,
    input  logic [3:0] d_srcB,
    input  logic [3:0] e_icode,
    input  logic [3:0] e_dstM,
    input  logic       e_cnd,
    input  logic [3:0] m_icode,
    input  logic [2:0] m_stat,
    input  logic [2:0] w_stat,
    output logic       f_stall,
    output logic       d_stall,
    output logic       d_bubble,
    output logic       e_bubble,
    output logic       m_bubble,
    output logic       w_stall,
    output logic       set_cc,
    output logic [2:0] cpu_stat,
    output logic       halted
`ifdef PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bub_cnt
`endif
);

    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_POPQ   = 4'hB;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [2:0] STAT_AOK = 3'b001;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2,
        S_ILLEGAL = 2'd3
    } state_t;

    state_t state_r;
    state_t next_state_s;

    logic lu_s;
    logic ret_s;
    logic misp_s;
    logic exc_s;
    logic w_bad_s;

    function automatic logic stat_is_aok(input logic [2:0] stat);
        return stat == STAT_AOK;
    endfunction

    assign lu_s    = ((e_icode == I_MRMOVQ) || (e_icode == I_POPQ)) && (e_dstM != RNONE) &&
                     ((e_dstM == d_srcA) || (e_dstM == d_srcB));
    assign ret_s   = (d_icode == I_RET) || (e_icode == I_RET) || (m_icode == I_RET);
    assign misp_s  = (e_icode == I_JXX) && !e_cnd;
    assign exc_s   = !stat_is_aok(m_stat) || !stat_is_aok(w_stat);
    assign w_bad_s = !stat_is_aok(w_stat);
    assign halted  = (state_r == S_HALTED);

    // Run-state register and architectural status latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= S_IDLE;
            cpu_stat <= STAT_AOK;
        end else begin
            state_r <= next_state_s;
            if ((state_r == S_RUN) && w_bad_s) begin
                cpu_stat <= w_stat;
            end else begin
                cpu_stat <= cpu_stat;
            end
        end
    end

    // Next-state and pipeline control decode; IDLE values are the safe default.
    always_comb begin
        next_state_s = state_r;
        f_stall      = 1'b1;
        d_stall      = 1'b0;
        d_bubble     = 1'b1;
        e_bubble     = 1'b1;
        m_bubble     = 1'b1;
        w_stall      = 1'b0;
        set_cc       = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (go) begin
                    next_state_s = S_RUN;
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            S_RUN: begin
                f_stall  = lu_s | ret_s;
                // A mispredict squashes D, so it overrides a load-use hold.
                d_stall  = lu_s & !misp_s;
                d_bubble = misp_s | (ret_s & !lu_s);
                e_bubble = misp_s | lu_s;
                m_bubble = exc_s;
                w_stall  = w_bad_s;
                set_cc   = (e_icode == I_OPQ) & !exc_s;
                if (w_bad_s) begin
                    next_state_s = S_HALTED;
                end else begin
                    next_state_s = S_RUN;
                end
            end
            S_HALTED: begin
                f_stall      = 1'b1;
                d_stall      = 1'b1;
                d_bubble     = 1'b0;
                e_bubble     = 1'b0;
                m_bubble     = 1'b1;
                w_stall      = 1'b1;
                next_state_s = S_HALTED;
            end
            default: begin
                next_state_s = S_IDLE;
            end
        endcase
    end

`ifdef PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Saturating RUN-only performance counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_cnt   <= {CNT_W{1'b0}};
            stall_cnt <= {CNT_W{1'b0}};
            bub_cnt   <= {CNT_W{1'b0}};
        end else if (state_r == S_RUN) begin
            if (cyc_cnt != CNT_MAX) cyc_cnt <= cyc_cnt + CNT_ONE;
            else cyc_cnt <= cyc_cnt;
            if (lu_s && (stall_cnt != CNT_MAX)) stall_cnt <= stall_cnt + CNT_ONE;
            else stall_cnt <= stall_cnt;
            if ((misp_s || ret_s) && (bub_cnt != CNT_MAX)) bub_cnt <= bub_cnt + CNT_ONE;
            else bub_cnt <= bub_cnt;
        end else begin
            cyc_cnt   <= cyc_cnt;
            stall_cnt <= stall_cnt;
            bub_cnt   <= bub_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl; covers counters when PERF_CNT_EN is defined.
module tb_pipe_ctrl;

    logic       clk = 1'b0;
    logic       rst, go;
    logic [3:0] d_icode, d_srcA, d_srcB, e_icode, e_dstM, m_icode;
    logic       e_cnd;
    logic [2:0] m_stat, w_stat;
    logic       f_stall, d_stall, d_bubble, e_bubble, m_bubble, w_stall, set_cc, halted;
    logic [2:0] cpu_stat;
    logic [6:0] ctl;
`ifdef PERF_CNT_EN
    logic [31:0] cyc_cnt, stall_cnt, bub_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // {f_stall,d_stall,d_bubble,e_bubble,m_bubble,w_stall,set_cc}
    localparam logic [6:0] C_IDLE = 7'b1011100;
    localparam logic [6:0] C_HALT = 7'b1100110;
    localparam logic [6:0] C_NONE = 7'b0000000;
    localparam logic [6:0] C_LU   = 7'b1101000;
    localparam logic [6:0] C_MISP = 7'b0011000;
    localparam logic [6:0] C_RET  = 7'b1010000;
    localparam logic [6:0] C_CC   = 7'b0000001;
    localparam logic [6:0] C_MEXC = 7'b0000100;
    localparam logic [6:0] C_WEXC = 7'b0000110;

    assign ctl = {f_stall, d_stall, d_bubble, e_bubble, m_bubble, w_stall, set_cc};

    always #5 clk = ~clk;

    pipe_ctrl dut (
        .clk(clk), .rst(rst), .go(go),
        .d_icode(d_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .e_icode(e_icode), .e_dstM(e_dstM), .e_cnd(e_cnd),
        .m_icode(m_icode), .m_stat(m_stat), .w_stat(w_stat),
        .f_stall(f_stall), .d_stall(d_stall), .d_bubble(d_bubble),
        .e_bubble(e_bubble), .m_bubble(m_bubble), .w_stall(w_stall),
        .set_cc(set_cc), .cpu_stat(cpu_stat), .halted(halted)
`ifdef PERF_CNT_EN
        , .cyc_cnt(cyc_cnt), .stall_cnt(stall_cnt), .bub_cnt(bub_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic nops();
        d_icode = 4'h1; d_srcA = 4'hF; d_srcB = 4'hF;
        e_icode = 4'h1; e_dstM = 4'hF; e_cnd = 1'b1;
        m_icode = 4'h1; m_stat = 3'b001; w_stat = 3'b001;
        #1;
    endtask

    initial begin
        rst = 1'b1; go = 1'b0;
        nops();
        tick();
        rst = 1'b0;
        // T1: idle holds for 5 cycles, even with hazard-looking inputs
        for (int i = 0; i < 5; i++) begin
            check("idle_ctl", {25'd0, ctl}, {25'd0, C_IDLE});
            check("idle_stat", {29'd0, cpu_stat}, 32'd1);
            check("idle_halted", {31'd0, halted}, 32'd0);
            tick();
        end
        e_icode = 4'h5; e_dstM = 4'h2; d_srcA = 4'h2; #1;
        check("idle_ignores_lu", {25'd0, ctl}, {25'd0, C_IDLE});
        nops();
        go = 1'b1; tick(); go = 1'b0;
        check("run_nop", {25'd0, ctl}, {25'd0, C_NONE});

        // T2: load-use on srcA for one cycle
        e_icode = 4'h5; e_dstM = 4'h2; d_srcA = 4'h2; #1;
        check("lu_srcA", {25'd0, ctl}, {25'd0, C_LU});
        tick(); nops();
        check("lu_cleared", {25'd0, ctl}, {25'd0, C_NONE});
        e_icode = 4'hB; e_dstM = 4'h3; d_srcB = 4'h3; #1;
        check("lu_popq_srcB", {25'd0, ctl}, {25'd0, C_LU});
        e_dstM = 4'hF; d_srcB = 4'hF; d_srcA = 4'hF; #1;
        check("lu_rnone", {25'd0, ctl}, {25'd0, C_NONE});

        // T3: mispredict
        nops(); e_icode = 4'h7; e_cnd = 1'b0; d_srcB = 4'h4; #1;
        check("misp", {25'd0, ctl}, {25'd0, C_MISP});
        e_cnd = 1'b1; #1;
        check("jxx_taken", {25'd0, ctl}, {25'd0, C_NONE});
        nops(); d_icode = 4'h9; e_icode = 4'h5; e_dstM = 4'h3; d_srcB = 4'h3; #1;
        check("lu_beats_ret", {25'd0, ctl}, {25'd0, C_LU});

        // T4: RET walking D->E->M
        nops(); d_icode = 4'h9; #1;
        check("ret_d", {25'd0, ctl}, {25'd0, C_RET});
        tick(); d_icode = 4'h1; e_icode = 4'h9; #1;
        check("ret_e", {25'd0, ctl}, {25'd0, C_RET});
        tick(); e_icode = 4'h1; m_icode = 4'h9; #1;
        check("ret_m", {25'd0, ctl}, {25'd0, C_RET});
        tick(); nops();
        check("ret_done", {25'd0, ctl}, {25'd0, C_NONE});

        // set_cc and T5 exception drain to HALTED
        e_icode = 4'h6; #1;
        check("set_cc", {25'd0, ctl}, {25'd0, C_CC});
        m_stat = 3'b100; #1;
        check("m_exc", {25'd0, ctl}, {25'd0, C_MEXC});
        tick(); m_stat = 3'b001; w_stat = 3'b100; e_icode = 4'h1; #1;
        check("w_exc", {25'd0, ctl}, {25'd0, C_WEXC});
        check("w_exc_not_halted", {31'd0, halted}, 32'd0);
        check("w_exc_stat", {29'd0, cpu_stat}, 32'd1);
        tick();
        check("halt_ctl", {25'd0, ctl}, {25'd0, C_HALT});
        check("halt_flag", {31'd0, halted}, 32'd1);
        check("halt_stat", {29'd0, cpu_stat}, 32'd4);
        w_stat = 3'b001; go = 1'b1; tick(); go = 1'b0;
        check("halt_sticky", {31'd0, halted}, 32'd1);
        check("halt_stat_held", {29'd0, cpu_stat}, 32'd4);
        check("halt_ctl_held", {25'd0, ctl}, {25'd0, C_HALT});
        rst = 1'b1; go = 1'b1; tick(); rst = 1'b0; go = 1'b0;
        check("rst_from_halt_ctl", {25'd0, ctl}, {25'd0, C_IDLE});
        check("rst_from_halt_stat", {29'd0, cpu_stat}, 32'd1);
        check("rst_from_halt_flag", {31'd0, halted}, 32'd0);

        // INS exception, then reset mid-RUN
        go = 1'b1; tick(); go = 1'b0;
        w_stat = 3'b010; tick(); w_stat = 3'b001; #1;
        check("ins_halt_stat", {29'd0, cpu_stat}, 32'd2);
        check("ins_halt_flag", {31'd0, halted}, 32'd1);
        rst = 1'b1; tick(); rst = 1'b0;
        go = 1'b1; tick(); go = 1'b0;
        check("rerun_ctl", {25'd0, ctl}, {25'd0, C_NONE});
        rst = 1'b1; tick(); rst = 1'b0;
        check("rst_mid_run_ctl", {25'd0, ctl}, {25'd0, C_IDLE});
        check("rst_mid_run_stat", {29'd0, cpu_stat}, 32'd1);

`ifdef PERF_CNT_EN
        // T6: 10 RUN cycles with 2 load-use and 1 mispredict
        check("cnt_clear", cyc_cnt, 32'd0);
        go = 1'b1; tick(); go = 1'b0;
        for (int i = 0; i < 10; i++) begin
            nops();
            if (i == 2 || i == 5) begin
                e_icode = 4'h5; e_dstM = 4'h2; d_srcA = 4'h2; #1;
            end else if (i == 7) begin
                e_icode = 4'h7; e_cnd = 1'b0; #1;
            end
            tick();
        end
        nops();
        rst = 1'b0;
        check("cyc_cnt", cyc_cnt, 32'd10);
        check("stall_cnt", stall_cnt, 32'd2);
        check("bub_cnt", bub_cnt, 32'd1);
        rst = 1'b1; tick(); rst = 1'b0;
        check("cnt_rst", cyc_cnt, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
